// File: rtl/alarme_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alarme_ctrl_pkg
//
// Shared definitions for the alarm controller:
//   - state_t   : FSM state codes (IDLE=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4).
//                 Codes 5..7 are illegal and are steered back to IDLE.
//   - DISP_W    : width of the saturating trigger counter.
//   - DISP_MAX  : saturation value of the trigger counter.
//   - is_delay_state() : true in the states where the shared timer counts.
// -----------------------------------------------------------------------------
package alarme_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXIT  = 3'd1,
    ST_ARMED = 3'd2,
    ST_ENTRY = 3'd3,
    ST_ALARM = 3'd4
  } state_t;

  localparam int unsigned DISP_W = 4;
  localparam logic [DISP_W-1:0] DISP_MAX = '1;

  // The timer only runs while a delay (exit, entry or siren) is in progress.
  function automatic logic is_delay_state(input state_t st);
    return (st == ST_EXIT) || (st == ST_ENTRY) || (st == ST_ALARM);
  endfunction

endpackage

// File: rtl/alarme_timer.sv
// -----------------------------------------------------------------------------
// alarme_timer
//
// Loadable down-counter shared by the exit, entry and siren delays.
//
// Ports:
//   clk    in  1      rising-edge clock
//   rst_n  in  1      asynchronous active-low reset (count -> 0)
//   load   in  1      load `val` into the counter (wins over `en`)
//   val    in  TW     value to load
//   en     in  1      decrement by one when the count is nonzero
//   zero   out 1      count is zero
//
// The count never wraps: with `en` high and the count at zero it holds at 0.
// -----------------------------------------------------------------------------
module alarme_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] val,
  input  logic          en,
  output logic          zero
);

  logic [TW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alarme_ctrl.sv
// -----------------------------------------------------------------------------
// alarme_ctrl
//
// Moore controller for the alarm system: arming/disarming, exit delay, entry
// delay and a timed siren, all sharing one countdown timer (alarme_timer).
//
// Parameters:
//   EXIT_CYC   exit-delay length in cycles (>= 1)
//   ENTRY_CYC  entry-delay length in cycles (>= 1)
//   SIREN_CYC  siren-on length in cycles (>= 1)
//   TW         timer width, 2**TW > max(EXIT_CYC, ENTRY_CYC, SIREN_CYC)
//
// Ports:
//   clk       in  1  system clock, rising edge
//   rst_n     in  1  asynchronous active-low reset
//   arm       in  1  arm request pulse
//   disarm    in  1  disarm request pulse (highest priority event)
//   sensor    in  1  intrusion flag from the detector, level-sensitive
//   sirene    out 1  siren drive, high only in ALARM
//   armado    out 1  armed LED, high in ARMED or ENTRY
//   saida     out 1  exit-delay LED, high in EXIT
//   estado    out 3  current state code (also the FSM debug view)
//   disparos  out 4  saturating count of alarm triggers, cleared only by reset
//
// Input protocol: arm and disarm are single-cycle pulses from the debounced
// panel, sensor is a level. All three are sampled at every rising edge with
// no backpressure; an event sampled at edge k is visible after edge k.
//
// Delay timing: entering a delay state loads the timer with CYC-1 at the
// same edge, so the state shows CYC-1, ..., 0 and leaves on the edge that
// sees 0, giving exactly CYC cycles of dwell (one cycle when CYC is 1).
// -----------------------------------------------------------------------------
module alarme_ctrl
  import alarme_ctrl_pkg::*;
#(
  parameter int EXIT_CYC  = 8,
  parameter int ENTRY_CYC = 6,
  parameter int SIREN_CYC = 10,
  parameter int TW        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              disarm,
  input  logic              sensor,
  output logic              sirene,
  output logic              armado,
  output logic              saida,
  output logic [2:0]        estado,
  output logic [DISP_W-1:0] disparos
);

  localparam logic [TW-1:0] EXIT_LOAD  = TW'(EXIT_CYC - 1);
  localparam logic [TW-1:0] ENTRY_LOAD = TW'(ENTRY_CYC - 1);
  localparam logic [TW-1:0] SIREN_LOAD = TW'(SIREN_CYC - 1);

  state_t        state;
  state_t        nxt;
  logic          t_load;
  logic [TW-1:0] t_val;
  logic          t_en;
  logic          t_zero;
  logic          trig;

  // ---------------------------------------------------------------------------
  // Next-state and timer control. disarm is tested first in every state so it
  // overrides arm, sensor and timer expiry arriving in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    nxt    = state;
    t_load = 1'b0;
    t_val  = '0;
    trig   = 1'b0;

    case (state)
      ST_IDLE: begin
        // sensor is ignored while disarmed
        if (!disarm && arm) begin
          nxt    = ST_EXIT;
          t_load = 1'b1;
          t_val  = EXIT_LOAD;
        end
      end

      ST_EXIT: begin
        // sensor is ignored so the user can walk out
        if (disarm) begin
          nxt = ST_IDLE;
        end else if (t_zero) begin
          nxt = ST_ARMED;
        end
      end

      ST_ARMED: begin
        if (disarm) begin
          nxt = ST_IDLE;
        end else if (sensor) begin
          nxt    = ST_ENTRY;
          t_load = 1'b1;
          t_val  = ENTRY_LOAD;
        end
      end

      ST_ENTRY: begin
        // further sensor activity does not restart the entry delay
        if (disarm) begin
          nxt = ST_IDLE;
        end else if (t_zero) begin
          nxt    = ST_ALARM;
          t_load = 1'b1;
          t_val  = SIREN_LOAD;
          trig   = 1'b1;
        end
      end

      ST_ALARM: begin
        // siren expiry re-arms; a still-active sensor re-enters ENTRY next edge
        if (disarm) begin
          nxt = ST_IDLE;
        end else if (t_zero) begin
          nxt = ST_ARMED;
        end
      end

      default: begin
        nxt = ST_IDLE;
      end
    endcase

    // A disarm freezes the timer; the next delay entry reloads it anyway.
    t_en = is_delay_state(state) && !disarm;
  end

  alarme_timer #(
    .TW (TW)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (t_load),
    .val   (t_val),
    .en    (t_en),
    .zero  (t_zero)
  );

  // ---------------------------------------------------------------------------
  // State register, registered Moore outputs and trigger counter. Outputs are
  // decoded from the next state so they line up with the state register and
  // have no combinational path from the inputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      sirene   <= 1'b0;
      armado   <= 1'b0;
      saida    <= 1'b0;
      disparos <= '0;
    end else begin
      state  <= nxt;
      sirene <= (nxt == ST_ALARM);
      armado <= (nxt == ST_ARMED) || (nxt == ST_ENTRY);
      saida  <= (nxt == ST_EXIT);
      if (trig && (disparos != DISP_MAX)) begin
        disparos <= disparos + 1'b1;
      end
    end
  end

  assign estado = state;

endmodule

// File: tb/tb_alarme_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alarme_ctrl
//
// Directed bench for alarme_ctrl with EXIT=4, ENTRY=3, SIREN=5. Inputs change
// 1 ns after each rising edge and outputs are sampled at that same point.
// Expected output words are {sirene, armado, saida, estado}.
// -----------------------------------------------------------------------------
module tb_alarme_ctrl;

  localparam int EXIT_CYC  = 4;
  localparam int ENTRY_CYC = 3;
  localparam int SIREN_CYC = 5;
  localparam int TW        = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       arm    = 1'b0;
  logic       disarm = 1'b0;
  logic       sensor = 1'b0;
  logic       sirene;
  logic       armado;
  logic       saida;
  logic [2:0] estado;
  logic [3:0] disparos;

  always #5 clk = ~clk;

  alarme_ctrl #(
    .EXIT_CYC  (EXIT_CYC),
    .ENTRY_CYC (ENTRY_CYC),
    .SIREN_CYC (SIREN_CYC),
    .TW        (TW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .arm      (arm),
    .disarm   (disarm),
    .sensor   (sensor),
    .sirene   (sirene),
    .armado   (armado),
    .saida    (saida),
    .estado   (estado),
    .disparos (disparos)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [5:0] exp_q[$];

  // Reference decode of the Moore outputs for a state code.
  function automatic logic [5:0] outs(input int st);
    logic s_sir;
    logic s_arm;
    logic s_sai;
    s_sir = (st == 4);
    s_arm = (st == 2) || (st == 3);
    s_sai = (st == 1);
    return {s_sir, s_arm, s_sai, 3'(st)};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic d, input logic s);
    arm    = a;
    disarm = d;
    sensor = s;
  endtask

  function automatic logic [7:0] obs_word();
    return {2'b00, sirene, armado, saida, estado};
  endfunction

  task automatic push(input int st, input int times);
    for (int k = 0; k < times; k++) exp_q.push_back(outs(st));
  endtask

  // One edge per queued entry, compared against the head of the queue.
  task automatic run_queue(input string tag);
    logic [5:0] e;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      check(tag, obs_word(), {2'b00, e});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    // Reset state
    tick();
    tick();
    check("reset_outs", obs_word(), {2'b00, outs(0)});
    check("reset_disparos", {4'b0, disparos}, 8'd0);
    rst_n = 1'b1;

    // Sensor ignored in IDLE
    drive(0, 0, 1);
    tick();
    check("idle_ignores_sensor", obs_word(), {2'b00, outs(0)});

    // Arm with sensor held: EXIT 4 cycles, ARMED, then ENTRY next edge
    drive(1, 0, 1);
    tick();
    check("exit_enter", obs_word(), {2'b00, outs(1)});
    drive(0, 0, 1);
    push(1, 3);
    push(2, 1);
    push(3, 1);
    run_queue("exit_to_entry");

    // Sensor drops: ENTRY 3 cycles in total, ALARM 5 cycles, back to ARMED
    drive(0, 0, 0);
    push(3, 2);
    push(4, 5);
    push(2, 2);
    run_queue("entry_alarm_rearm");
    check("disparos_first", {4'b0, disparos}, 8'd1);

    // arm in ARMED is ignored
    drive(1, 0, 0);
    tick();
    check("arm_in_armed", obs_word(), {2'b00, outs(2)});

    // Disarm coinciding with ENTRY expiry
    drive(0, 0, 1);
    tick();
    check("entry_again", obs_word(), {2'b00, outs(3)});
    drive(0, 0, 0);
    push(3, 2);
    run_queue("entry_hold");
    drive(0, 1, 0);
    tick();
    check("disarm_at_expiry", obs_word(), {2'b00, outs(0)});
    check("disparos_unchanged", {4'b0, disparos}, 8'd1);
    drive(0, 0, 0);
    tick();
    check("siren_stays_low", {7'b0, sirene}, 8'd0);

    // arm and disarm together in IDLE
    drive(1, 1, 0);
    tick();
    check("arm_disarm_idle", obs_word(), {2'b00, outs(0)});

    // Disarm mid-EXIT, then re-arm: full exit delay again
    drive(1, 0, 0);
    tick();
    drive(0, 0, 0);
    tick();
    drive(0, 1, 0);
    tick();
    check("disarm_in_exit", obs_word(), {2'b00, outs(0)});
    drive(1, 0, 0);
    tick();
    check("rearm_exit", obs_word(), {2'b00, outs(1)});
    drive(0, 0, 0);
    push(1, 3);
    push(2, 1);
    run_queue("rearm_full_exit");

    // Trigger, then disarm during ALARM drops the siren
    drive(0, 0, 1);
    push(3, 3);
    push(4, 2);
    run_queue("to_alarm");
    drive(0, 1, 1);
    tick();
    check("disarm_in_alarm", obs_word(), {2'b00, outs(0)});
    check("disparos_second", {4'b0, disparos}, 8'd2);
    drive(0, 0, 0);

    // Illegal state code returns to IDLE
    force dut.state = alarme_ctrl_pkg::state_t'(3'd6);
    #1;
    release dut.state;
    tick();
    check("illegal_to_idle", {5'b0, estado}, 8'd0);

    // Saturation: sensor held, triggers every 9 cycles after the exit delay
    drive(1, 0, 1);
    tick();
    drive(0, 0, 1);
    for (int i = 1; i <= 153; i++) begin
      tick();
      if (i == 115) begin
        check("sat_pre_disparos", {4'b0, disparos}, 8'd14);
        check("sat_pre_estado", {5'b0, estado}, 8'd3);
      end
      if (i == 116) begin
        check("sat_reach", {4'b0, disparos}, 8'd15);
        check("sat_reach_estado", obs_word(), {2'b00, outs(4)});
      end
      if (i == 151) check("sat_entry", {5'b0, estado}, 8'd3);
      if (i == 152) begin
        check("sat_hold", {4'b0, disparos}, 8'd15);
        check("sat_alarm", obs_word(), {2'b00, outs(4)});
      end
    end

    // Asynchronous reset mid-ALARM, no clock edge needed
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outs", obs_word(), {2'b00, outs(0)});
    check("async_rst_disparos", {4'b0, disparos}, 8'd0);
    drive(0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", obs_word(), {2'b00, outs(0)});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
